// File: rtl/temp_monitor.sv
// Moving-average temperature classifier with hysteresis FSM, alarm pulse and saturating alarm counter.
// Optional max-hold tracker (max_clr / max_temp) is compiled in with TEMP_MONITOR_MAX_HOLD_EN.
module temp_monitor #(
   parameter int AVG_LOG2 = 2,
   parameter int WARN_HI  = 80,
   parameter int ALARM_HI = 100,
   parameter int HYST     = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic [7:0] temp,
   output logic [7:0] avg_temp,
   output logic       avg_valid,
   output logic [1:0] state,
   output logic       alarm,
   output logic       alarm_pulse,
   output logic [7:0] alarm_count
`ifdef TEMP_MONITOR_MAX_HOLD_EN
   ,
   input  logic       max_clr,
   output logic [7:0] max_temp
`endif
);

   localparam int N     = 1 << AVG_LOG2;
   localparam int ACC_W = 8 + AVG_LOG2;

   localparam logic [8:0] WARN_ON   = 9'(WARN_HI);
   localparam logic [8:0] ALARM_ON  = 9'(ALARM_HI);
   localparam logic [8:0] WARN_OFF  = 9'(WARN_HI - HYST);
   localparam logic [8:0] ALARM_OFF = 9'(ALARM_HI - HYST);

   localparam logic [AVG_LOG2-1:0] PTR_ONE  = 1;
   localparam logic [AVG_LOG2:0]   FILL_ONE = 1;
   localparam logic [AVG_LOG2:0]   FILL_N   = N[AVG_LOG2:0];

   typedef enum logic [1:0] {
      ST_NORMAL = 2'b00,
      ST_WARN   = 2'b01,
      ST_ALARM  = 2'b10
   } state_t;

   logic [7:0]          samp_q [N];
   logic [7:0]          samp_d [N];
   logic [ACC_W-1:0]    acc_q, acc_d;
   logic [AVG_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [AVG_LOG2:0]   fill_q, fill_d;
   state_t              state_q, state_d;
   logic                pulse_q, pulse_d;
   logic [7:0]          count_q, count_d;
   logic [8:0]          avg9;
   logic                alarm_entry;

   assign avg_temp    = acc_q[ACC_W-1:AVG_LOG2];
   assign avg_valid   = (fill_q == FILL_N);
   assign state       = state_q;
   assign alarm       = (state_q == ST_ALARM);
   assign alarm_pulse = pulse_q;
   assign alarm_count = count_q;
   assign avg9        = {1'b0, avg_temp};

   // acc always equals the sum of the window, so the subtraction cannot underflow
   always_comb begin
      samp_d   = samp_q;
      acc_d    = acc_q;
      wr_ptr_d = wr_ptr_q;
      fill_d   = fill_q;
      if (tick) begin
         samp_d[wr_ptr_q] = temp;
         acc_d    = acc_q + {{AVG_LOG2{1'b0}}, temp} - {{AVG_LOG2{1'b0}}, samp_q[wr_ptr_q]};
         wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (fill_q != FILL_N) fill_d = fill_q + FILL_ONE;
      end
   end

   always_comb begin
      state_d = state_q;
      if (!avg_valid) begin
         state_d = ST_NORMAL;
      end else begin
         case (state_q)
            ST_NORMAL: begin
               if (avg9 >= ALARM_ON)     state_d = ST_ALARM;
               else if (avg9 >= WARN_ON) state_d = ST_WARN;
            end
            ST_WARN: begin
               if (avg9 >= ALARM_ON)     state_d = ST_ALARM;
               else if (avg9 < WARN_OFF) state_d = ST_NORMAL;
            end
            ST_ALARM: begin
               if (avg9 < WARN_OFF)       state_d = ST_NORMAL;
               else if (avg9 < ALARM_OFF) state_d = ST_WARN;
            end
            default: state_d = ST_NORMAL;
         endcase
      end
   end

   always_comb begin
      alarm_entry = (state_d == ST_ALARM) && (state_q != ST_ALARM);
      pulse_d     = alarm_entry;
      count_d     = count_q;
      if (alarm_entry && (count_q != 8'hFF)) count_d = count_q + 8'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N; i++) samp_q[i] <= '0;
         acc_q    <= '0;
         wr_ptr_q <= '0;
         fill_q   <= '0;
         state_q  <= ST_NORMAL;
         pulse_q  <= 1'b0;
         count_q  <= '0;
      end else begin
         samp_q   <= samp_d;
         acc_q    <= acc_d;
         wr_ptr_q <= wr_ptr_d;
         fill_q   <= fill_d;
         state_q  <= state_d;
         pulse_q  <= pulse_d;
         count_q  <= count_d;
      end
   end

`ifdef TEMP_MONITOR_MAX_HOLD_EN
   logic [7:0] max_q, max_d;

   assign max_temp = max_q;

   // a clear on a sampling edge restarts the peak from that sample
   always_comb begin
      max_d = max_q;
      if (max_clr)                    max_d = tick ? temp : 8'd0;
      else if (tick && (temp > max_q)) max_d = temp;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) max_q <= '0;
      else       max_q <= max_d;
   end
`endif

endmodule
